sbytes_engine: RTL and testbench

// Parametrised AES SubBytes engine. Reads block_count 128-bit state blocks from SRAM at src_addr.

---
 rtl/sbytes_engine_if.sv | 29 ++
 rtl/sbytes_engine.sv | 169 ++++++++++++++++
 tb/tb_sbytes_engine.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sbytes_engine_if.sv
// Control handshake and SRAM bus of the SubBytes engine.
// master = engine side, slave = round controller / SRAM side.
interface sbytes_engine_if #(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 4
);
   logic              sbytes_enable;
   logic              inv_mode;
   logic [ADDR_W-1:0] src_addr;
   logic [ADDR_W-1:0] dst_addr;
   logic [CNT_W-1:0]  block_count;
   logic [127:0]      sramread_data;
   logic              sramread;
   logic              sramwrite;
   logic [ADDR_W-1:0] sramaddr;
   logic [127:0]      sramwrite_data;
   logic              sbytes_busy;
   logic              sbytes_finished;

   modport master (
      input  sbytes_enable, inv_mode, src_addr, dst_addr, block_count, sramread_data,
      output sramread, sramwrite, sramaddr, sramwrite_data, sbytes_busy, sbytes_finished
   );

   modport slave (
      output sbytes_enable, inv_mode, src_addr, dst_addr, block_count, sramread_data,
      input  sramread, sramwrite, sramaddr, sramwrite_data, sbytes_busy, sbytes_finished
   );
endinterface

// File: rtl/sbytes_engine.sv
// AES SubBytes engine: read block, substitute LANES bytes/cycle, write block, repeat.
// Define INV_SBOX_EN to build the inverse S-box per lane (selected by inv_mode).
module sbytes_lane (
   input  logic       inv,
   input  logic [7:0] din,
   output logic [7:0] dout
);
   // Byte x of each table sits at bits [8*(255-x) +: 8], i.e. index {~x, 3'b000}.
   localparam logic [2047:0] FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic [7:0] fwd_b;
   assign fwd_b = FWD[{~din, 3'b000} +: 8];

`ifdef INV_SBOX_EN
   localparam logic [2047:0] INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
   assign dout = inv ? INV[{~din, 3'b000} +: 8] : fwd_b;
`else
   logic unused_inv;
   assign unused_inv = inv;
   assign dout       = fwd_b;
`endif
endmodule

module sbytes_engine #(
   parameter int ADDR_W    = 16,
   parameter int LANES     = 16,
   parameter int ADDR_STEP = 1,
   parameter int CNT_W     = 4
) (
   input  logic           clk,
   input  logic           rst,
   sbytes_engine_if.master bus
);
   localparam int NSUB = 16 / LANES;

   typedef enum logic [2:0] {IDLE, READ, SUB, WRITE, DONE, HOLD} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    src_q, src_d, dst_q, dst_d, addr_q, addr_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [CNT_W:0]       blk_q, blk_d;
   logic [3:0]           sub_q, sub_d;
   logic                 inv_q, inv_d, rd_q, rd_d, wr_q, wr_d;
   logic                 busy_q, busy_d, fin_q, fin_d;
   logic [15:0][7:0]     data_q, data_d;
   logic [127:0]         wdata_q, wdata_d;
   logic [LANES-1:0][7:0] lane_in, lane_out;
   logic [LANES-1:0][3:0] lane_idx;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_idx[l] = 4'(int'(sub_q) * LANES + l);
      assign lane_in[l]  = data_q[lane_idx[l]];
      sbytes_lane u_lane (.inv(inv_q), .din(lane_in[l]), .dout(lane_out[l]));
   end

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      cnt_d   = cnt_q;
      blk_d   = blk_q;
      sub_d   = sub_q;
      inv_d   = inv_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: if (bus.sbytes_enable) begin
            src_d = bus.src_addr;
            dst_d = bus.dst_addr;
            cnt_d = bus.block_count;
            blk_d = '0;
            sub_d = '0;
`ifdef INV_SBOX_EN
            inv_d = bus.inv_mode;
`else
            inv_d = 1'b0;
`endif
            state_d = (bus.block_count == '0) ? DONE : READ;
         end
         READ: begin
            data_d  = bus.sramread_data;
            sub_d   = '0;
            state_d = SUB;
         end
         SUB: begin
            for (int l = 0; l < LANES; l++) data_d[lane_idx[l]] = lane_out[l];
            if (sub_q == 4'(NSUB - 1)) state_d = WRITE;
            else                       sub_d   = sub_q + 4'd1;
         end
         WRITE: begin
            src_d   = src_q + ADDR_W'(ADDR_STEP);
            dst_d   = dst_q + ADDR_W'(ADDR_STEP);
            blk_d   = blk_q + (CNT_W+1)'(1);
            state_d = (blk_d == {1'b0, cnt_q}) ? DONE : READ;
         end
         DONE:    state_d = HOLD;
         HOLD:    if (!bus.sbytes_enable) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs are registered: decode them from the state being entered.
      rd_d    = (state_d == READ);
      wr_d    = (state_d == WRITE);
      fin_d   = (state_d == DONE);
      busy_d  = !(state_d inside {IDLE, HOLD});
      addr_d  = rd_d ? src_d : (wr_d ? dst_d : '0);
      wdata_d = wr_d ? data_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         blk_q   <= '0;
         sub_q   <= '0;
         inv_q   <= 1'b0;
         data_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
         sub_q   <= sub_d;
         inv_q   <= inv_d;
         data_q  <= data_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         busy_q  <= busy_d;
         fin_q   <= fin_d;
      end
   end

`ifndef INV_SBOX_EN
   logic unused_inv_mode;
   assign unused_inv_mode = bus.inv_mode;
`endif

   assign bus.sramread        = rd_q;
   assign bus.sramwrite       = wr_q;
   assign bus.sramaddr        = addr_q;
   assign bus.sramwrite_data  = wdata_q;
   assign bus.sbytes_busy     = busy_q;
   assign bus.sbytes_finished = fin_q;
endmodule

// File: tb/tb_sbytes_engine.sv
// Bench: a LANES=16 and a LANES=1 engine share one stimulus; each has its own SRAM model and scoreboard.
`timescale 1ns/1ps
module tb_sbytes_engine;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      logic        inv;
      logic        fill;
      logic [15:0] src;
      logic [15:0] dst;
      logic [3:0]  cnt;
      int          lat16;
      int          lat1;
   } vec_t;

   typedef struct packed {
      logic [15:0]  a;
      logic [127:0] d;
   } wexp_t;

   logic         en = 1'b0, inv = 1'b0;
   logic [15:0]  src = '0, dst = '0;
   logic [3:0]   cnt = '0;
   logic         ld_en = 1'b0;
   logic [15:0]  ld_addr = '0;
   logic [127:0] ld_data = '0;

   logic [127:0] mem [2][65536];
   logic [15:0]  rq [2][$];
   wexp_t        wq [2][$];
   int           nrd [2], nwr [2], fin_at [2];
   int           cyc = 0, st_cyc = 0;
   int           errors = 0, checks = 0;

   sbytes_engine_if #(.ADDR_W(16), .CNT_W(4)) if16 ();
   sbytes_engine_if #(.ADDR_W(16), .CNT_W(4)) if1 ();

   assign if16.sbytes_enable = en;
   assign if16.inv_mode      = inv;
   assign if16.src_addr      = src;
   assign if16.dst_addr      = dst;
   assign if16.block_count   = cnt;
   assign if1.sbytes_enable  = en;
   assign if1.inv_mode       = inv;
   assign if1.src_addr       = src;
   assign if1.dst_addr       = dst;
   assign if1.block_count    = cnt;
   assign if16.sramread_data = if16.sramread ? mem[0][if16.sramaddr] : '0;
   assign if1.sramread_data  = if1.sramread ? mem[1][if1.sramaddr] : '0;

   sbytes_engine #(.ADDR_W(16), .LANES(16), .ADDR_STEP(1), .CNT_W(4)) u_dut16 (
      .clk(clk), .rst(rst), .bus(if16));
   sbytes_engine #(.ADDR_W(16), .LANES(1), .ADDR_STEP(1), .CNT_W(4)) u_dut1 (
      .clk(clk), .rst(rst), .bus(if1));

   logic [1:0]   rd, wr, fin, busy;
   logic [15:0]  addr [2];
   logic [127:0] wdat [2];
   assign rd   = {if1.sramread, if16.sramread};
   assign wr   = {if1.sramwrite, if16.sramwrite};
   assign fin  = {if1.sbytes_finished, if16.sbytes_finished};
   assign busy = {if1.sbytes_busy, if16.sbytes_busy};
   assign addr[0] = if16.sramaddr;
   assign addr[1] = if1.sramaddr;
   assign wdat[0] = if16.sramwrite_data;
   assign wdat[1] = if1.sramwrite_data;

   task automatic chk(input string nm, input logic ok, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference S-box built from GF(2^8) inversion and the affine map.
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] fsb(input logic [7:0] x);
      logic [7:0] r, bs, e;
      r = 8'h01; bs = x; e = 8'd254;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gmul(r, bs);
         bs = gmul(bs, bs);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] isb(input logic [7:0] x);
      for (int y = 0; y < 256; y++) if (fsb(8'(y)) == x) return 8'(y);
      return 8'h00;
   endfunction

   function automatic logic [127:0] blk_model(input logic [127:0] d, input logic use_inv);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = use_inv ? isb(d[8*i +: 8]) : fsb(d[8*i +: 8]);
      return o;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) if (wr[k]) mem[k][addr[k]] <= wdat[k];
      if (ld_en) for (int k = 0; k < 2; k++) mem[k][ld_addr] <= ld_data;
   end

   always @(posedge clk) begin : mon
      logic [15:0] ea;
      wexp_t       ew;
      #1;
      for (int k = 0; k < 2; k++) begin
         if (rd[k]) begin
            nrd[k]++;
            if (rq[k].size() == 0) chk($sformatf("unexpected_read%0d", k), 1'b0, 128'(addr[k]), 0);
            else begin
               ea = rq[k].pop_front();
               chk($sformatf("read_addr%0d", k), addr[k] == ea, 128'(addr[k]), 128'(ea));
            end
         end
         if (wr[k]) begin
            nwr[k]++;
            if (wq[k].size() == 0) chk($sformatf("unexpected_write%0d", k), 1'b0, 128'(addr[k]), 0);
            else begin
               ew = wq[k].pop_front();
               chk($sformatf("write_addr%0d", k), addr[k] == ew.a, 128'(addr[k]), 128'(ew.a));
               chk($sformatf("write_data%0d", k), wdat[k] == ew.d, wdat[k], ew.d);
            end
         end
         chk($sformatf("strobe_excl%0d", k), !(rd[k] && wr[k]), {rd[k], wr[k]}, 0);
         if (!rd[k] && !wr[k])
            chk($sformatf("idle_bus%0d", k), addr[k] == '0 && wdat[k] == '0, wdat[k] | 128'(addr[k]), 0);
         if (fin[k]) begin
            chk($sformatf("single_finish%0d", k), fin_at[k] < 0, 128'(fin_at[k] >= 0), 0);
            fin_at[k] = cyc - st_cyc + 1;
         end
      end
   end

   task automatic preload(input logic [15:0] a, input logic [127:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Drive one start, push the expected bus traffic, then wait for both engines to finish.
   task automatic start_run(input logic i_inv, input logic [15:0] s, input logic [15:0] d, input logic [3:0] c);
      logic  eff;
      wexp_t ew;
`ifdef INV_SBOX_EN
      eff = i_inv;
`else
      eff = 1'b0;
`endif
      @(negedge clk);
      inv = i_inv; src = s; dst = d; cnt = c;
      for (int k = 0; k < 2; k++) begin
         nrd[k] = 0; nwr[k] = 0; fin_at[k] = -1;
         for (int i = 0; i < int'(c); i++) begin
            rq[k].push_back(s + 16'(i));
            ew.a = d + 16'(i);
            ew.d = blk_model(mem[k][s + 16'(i)], eff);
            wq[k].push_back(ew);
         end
      end
      en = 1'b1;
      st_cyc = cyc + 1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      if (v.fill)
         for (int i = 0; i < int'(v.cnt); i++)
            preload(v.src + 16'(i), {$urandom, $urandom, $urandom, $urandom});
      start_run(v.inv, v.src, v.dst, v.cnt);
      @(posedge clk); #2;
      chk($sformatf("busy_start v%0d", idx), busy == 2'b11, 128'(busy), 3);
      n = 0;
      while (!(fin_at[0] >= 0 && fin_at[1] >= 0) && n < 600) begin
         @(posedge clk); #2;
         n++;
      end
      chk($sformatf("finish_timeout v%0d", idx), n < 600, n, 0);
      chk($sformatf("latency16 v%0d", idx), fin_at[0] == v.lat16, fin_at[0], v.lat16);
      chk($sformatf("latency1 v%0d", idx), fin_at[1] == v.lat1, fin_at[1], v.lat1);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("reads%0d v%0d", k, idx), nrd[k] == int'(v.cnt), nrd[k], v.cnt);
         chk($sformatf("writes%0d v%0d", k, idx), nwr[k] == int'(v.cnt), nwr[k], v.cnt);
         chk($sformatf("pending%0d v%0d", k, idx), rq[k].size() + wq[k].size() == 0,
             rq[k].size() + wq[k].size(), 0);
      end
      @(posedge clk); #2;
      chk($sformatf("busy_end v%0d", idx), busy == 2'b00, 128'(busy), 0);
      // Enable still held: both engines must sit in HOLD without restarting.
      repeat (3) @(posedge clk);
      #2;
      chk($sformatf("held_enable v%0d", idx), busy == 2'b00 && rd == 2'b00, {busy, rd}, 0);
      @(negedge clk);
      en = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      vec_t         tv [6];
      logic [127:0] exp20, exp21;
      tv[0] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 4'd1,  4,  19};
      tv[1] = '{1'b1, 1'b0, 16'h0010, 16'h0020, 4'd2,  7,  37};
      tv[2] = '{1'b0, 1'b1, 16'h0030, 16'h0030, 4'd0,  1,  1};
      tv[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0100, 4'd2,  7,  37};
      tv[4] = '{1'b1, 1'b1, 16'h0040, 16'h0040, 4'd3,  10, 55};
      tv[5] = '{1'b0, 1'b1, 16'h0200, 16'h0300, 4'd15, 46, 271};
`ifdef INV_SBOX_EN
      exp20 = {16{8'h00}}; exp21 = {16{8'h53}};
`else
      exp20 = {16{8'hFB}}; exp21 = {16{8'h55}};
`endif
      for (int k = 0; k < 2; k++) begin fin_at[k] = -1; nrd[k] = 0; nwr[k] = 0; end

      repeat (3) @(posedge clk);
      #2;
      chk("reset_outputs", busy == 0 && fin == 0 && rd == 0 && wr == 0, {busy, fin, rd, wr}, 0);
      @(negedge clk);
      rst = 1'b0;

      preload(16'h0000, 128'h0848F8E92A8DC69A2BE2F4A0BEE33D19);
      preload(16'h0010, {16{8'h63}});
      preload(16'h0011, {16{8'hED}});
      preload(16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF);

      for (int i = 0; i < 6; i++) run_vec(tv[i], i);

      for (int k = 0; k < 2; k++) begin
         chk($sformatf("fips_vector%0d", k), mem[k][16'h0000] == 128'h3052411EE55DB4B8F198BFE0AE1127D4,
             mem[k][16'h0000], 128'h3052411EE55DB4B8F198BFE0AE1127D4);
         chk($sformatf("dst20_%0d", k), mem[k][16'h0020] == exp20, mem[k][16'h0020], exp20);
         chk($sformatf("dst21_%0d", k), mem[k][16'h0021] == exp21, mem[k][16'h0021], exp21);
         chk($sformatf("src_kept%0d", k),
             mem[k][16'h0010] == {16{8'h63}} && mem[k][16'h0011] == {16{8'hED}},
             mem[k][16'h0010] ^ mem[k][16'h0011], {16{8'h63 ^ 8'hED}});
      end

      // Reset while the LANES=16 engine is substituting its second block.
      preload(16'h0500, {$urandom, $urandom, $urandom, $urandom});
      preload(16'h0501, {$urandom, $urandom, $urandom, $urandom});
      preload(16'h0600, 128'hBEEF);
      preload(16'h0601, 128'hDEAD);
      start_run(1'b0, 16'h0500, 16'h0600, 4'd2);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(posedge clk); #2;
      chk("abort_outputs", busy == 0 && fin == 0 && rd == 0 && wr == 0 &&
          addr[0] == 0 && addr[1] == 0, {busy, fin, rd, wr}, 0);
      for (int k = 0; k < 2; k++) begin rq[k].delete(); wq[k].delete(); end
      @(negedge clk);
      rst = 1'b0;
      repeat (25) @(posedge clk);
      #2;
      chk("abort_no_finish", fin_at[0] < 0 && fin_at[1] < 0, {fin_at[0] >= 0, fin_at[1] >= 0}, 0);
      chk("abort_no_write16", mem[0][16'h0601] == 128'hDEAD, mem[0][16'h0601], 128'hDEAD);
      chk("abort_no_write1", mem[1][16'h0600] == 128'hBEEF && mem[1][16'h0601] == 128'hDEAD,
          mem[1][16'h0600] ^ mem[1][16'h0601], 128'hBEEF ^ 128'hDEAD);

      run_vec('{1'b0, 1'b1, 16'h0700, 16'h0710, 4'd1, 4, 19}, 6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
